// File: rtl/reduce_handshake_pkg.sv
// Shared types and helpers for the reduce/handshake transmit block.
package reduce_handshake_pkg;

  localparam int PKG_WIDTH     = 5;
  localparam int PKG_LANES     = 3;
  // One primary consumer plus the broadcast lanes.
  localparam int NUM_CONSUMERS = PKG_LANES + 1;

  // One stored result: the raw operands plus the two precomputed reductions.
  typedef struct packed {
    logic [PKG_WIDTH-1:0] in2;
    logic [PKG_WIDTH-1:0] in1;
    logic                 orr;
    logic                 andr;
  } entry_t;

  // Returns {orr, andr} of the first operand.
  function automatic logic [1:0] reduce_bits(input logic [PKG_WIDTH-1:0] in1);
    return {|in1, &in1};
  endfunction

endpackage

// File: rtl/reduce_handshake_tx_fork.sv
// Fork tracker: one done bit per consumer, per-consumer valids for the
// current head entry, and a retire pulse once every consumer has taken it.
import reduce_handshake_pkg::*;

module hs_fork_tracker #(
  parameter int N = NUM_CONSUMERS
) (
  input  logic         CLK,
  input  logic         ASYNCRESET,
  input  logic         active,
  input  logic [N-1:0] ready,
  output logic [N-1:0] valid,
  output logic         retire
);

  logic [N-1:0] done_reg;
  logic [N-1:0] done_next;
  logic [N-1:0] fire;
  logic [N-1:0] done_after;

  // A consumer sees valid only until it has accepted the current entry.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_consumer
      assign valid[gi]      = active & ~done_reg[gi];
      assign fire[gi]       = valid[gi] & ready[gi];
      assign done_after[gi] = done_reg[gi] | fire[gi];
    end
  endgenerate

  // Retire when this cycle's transfers complete the full set of consumers.
  always_comb begin
    retire    = active & (&done_after);
    done_next = done_after;
    if (retire) begin
      done_next = '0;
    end
  end

  // Done-bit register; cleared on reset so a restarted head is offered fresh.
  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      done_reg <= '0;
    end else begin
      done_reg <= done_next;
    end
  end

endmodule

// File: rtl/reduce_handshake_tx.sv
// Transmit side of the reduce handshake: accepts operand pairs, computes
// the or/and reductions of in1, queues results and broadcasts each head
// entry to one primary port and LANES secondary lanes.
import reduce_handshake_pkg::*;

module reduce_handshake_tx #(
  parameter int WIDTH = PKG_WIDTH,
  parameter int DEPTH = 2,
  parameter int LANES = PKG_LANES
) (
  input  logic               CLK,
  input  logic               ASYNCRESET,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in1,
  input  logic [WIDTH-1:0]   in2,
  output logic               handshake_valid,
  input  logic               handshake_ready,
  output logic               out,
  output logic [2*WIDTH-1:0] out_data,
  output logic [LANES-1:0]   handshake_arr_valid,
  input  logic [LANES-1:0]   handshake_arr_ready,
  output logic               mon_temp1,
  output logic               mon_temp2
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int NC    = LANES + 1;

  // Storage is not reset: the count alone decides which slots are live.
  entry_t mem_reg [DEPTH];

  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0] count_reg, count_next;

  logic          push;
  logic          pop;
  logic          active;
  logic [1:0]    rb;
  entry_t        head;
  logic [NC-1:0] cons_ready;
  logic [NC-1:0] cons_valid;

  // Full check only looks at the stored count, so downstream readies never
  // reach in_ready; a full FIFO refuses even when the head retires.
  assign in_ready = ~ASYNCRESET & (count_reg < CNT_W'(DEPTH));
  assign push     = in_valid & in_ready;
  assign active   = (count_reg != '0);
  assign rb       = reduce_bits(in1);
  assign head     = mem_reg[rd_ptr_reg];

  // Consumer 0 is the primary port, consumers 1..LANES are the lanes.
  assign cons_ready          = {handshake_arr_ready, handshake_ready};
  assign handshake_valid     = cons_valid[0];
  assign handshake_arr_valid = cons_valid[NC-1:1];

  hs_fork_tracker #(
    .N (NC)
  ) u_fork (
    .CLK        (CLK),
    .ASYNCRESET (ASYNCRESET),
    .active     (active),
    .ready      (cons_ready),
    .valid      (cons_valid),
    .retire     (pop)
  );

  // Head taps are forced to zero when empty; they only change on retire.
  always_comb begin
    out       = 1'b0;
    out_data  = '0;
    mon_temp1 = 1'b0;
    mon_temp2 = 1'b0;
    if (active) begin
      out       = head.orr & head.andr;
      out_data  = {head.in2, head.in1};
      mon_temp1 = head.orr;
      mon_temp2 = head.andr;
    end
  end

  // Pointer and occupancy bookkeeping; power-of-two depth wraps naturally.
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (push) begin
      wr_ptr_next = wr_ptr_reg + 1'b1;
    end
    if (pop) begin
      rd_ptr_next = rd_ptr_reg + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  // Control state; reset empties the queue immediately.
  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  // Entry write on an accepted operand, reductions captured with the data.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem_reg[wr_ptr_reg] <= '{in2: in2, in1: in1, orr: rb[1], andr: rb[0]};
    end
  end

endmodule

// File: tb/tb_reduce_handshake_tx.sv
// Directed bench for reduce_handshake_tx with hand-computed expectations.
module tb_reduce_handshake_tx;

  localparam int WIDTH = 5;
  localparam int LANES = 3;

  logic               CLK = 1'b0;
  logic               ASYNCRESET;
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in1;
  logic [WIDTH-1:0]   in2;
  logic               handshake_valid;
  logic               handshake_ready;
  logic               out;
  logic [2*WIDTH-1:0] out_data;
  logic [LANES-1:0]   handshake_arr_valid;
  logic [LANES-1:0]   handshake_arr_ready;
  logic               mon_temp1;
  logic               mon_temp2;

  int total = 0;
  int bad   = 0;

  reduce_handshake_tx #(
    .WIDTH (WIDTH),
    .DEPTH (2),
    .LANES (LANES)
  ) dut (
    .CLK                 (CLK),
    .ASYNCRESET          (ASYNCRESET),
    .in_valid            (in_valid),
    .in_ready            (in_ready),
    .in1                 (in1),
    .in2                 (in2),
    .handshake_valid     (handshake_valid),
    .handshake_ready     (handshake_ready),
    .out                 (out),
    .out_data            (out_data),
    .handshake_arr_valid (handshake_arr_valid),
    .handshake_arr_ready (handshake_arr_ready),
    .mon_temp1           (mon_temp1),
    .mon_temp2           (mon_temp2)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Advance to 1ns after the next rising edge and check the monitor property.
  task automatic step();
    @(posedge CLK);
    #1;
    if (handshake_valid === 1'b1) begin
      check("prop", 32'(out), 32'(mon_temp1 & mon_temp2));
    end
  endtask

  task automatic set_ready(input logic hs, input logic [2:0] arr);
    handshake_ready     = hs;
    handshake_arr_ready = arr;
  endtask

  task automatic head(input string tag, input logic hv, input logic [2:0] av,
                      input logic [9:0] d);
    check({tag, ".hv"},   32'(handshake_valid),     32'(hv));
    check({tag, ".av"},   32'(handshake_arr_valid), 32'(av));
    check({tag, ".data"}, 32'(out_data),            32'(d));
  endtask

  logic [4:0] s_in1, s_in2;

  initial begin
    ASYNCRESET = 1'b1;
    in_valid   = 1'b0;
    in1        = '0;
    in2        = '0;
    set_ready(1'b0, 3'b000);

    // Reset state
    step();
    step();
    check("rst.in_ready", 32'(in_ready), 32'd0);
    head("rst", 1'b0, 3'b000, 10'h000);
    check("rst.out", 32'(out), 32'd0);
    check("rst.mt1", 32'(mon_temp1), 32'd0);
    ASYNCRESET = 1'b0;
    #1;
    check("rel.in_ready", 32'(in_ready), 32'd1);

    // Single transfer, all consumers ready
    set_ready(1'b1, 3'b111);
    in1 = 5'b11111; in2 = 5'h0A; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    head("single", 1'b1, 3'b111, 10'h15F);
    check("single.out", 32'(out), 32'd1);
    check("single.mt1", 32'(mon_temp1), 32'd1);
    check("single.mt2", 32'(mon_temp2), 32'd1);
    step();
    head("single.retired", 1'b0, 3'b000, 10'h000);

    // Mixed operands
    set_ready(1'b0, 3'b000);
    in1 = 5'b00100; in2 = 5'h03; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    head("mixed1", 1'b1, 3'b111, 10'h064);
    check("mixed1.out", 32'(out), 32'd0);
    check("mixed1.mt1", 32'(mon_temp1), 32'd1);
    check("mixed1.mt2", 32'(mon_temp2), 32'd0);
    set_ready(1'b1, 3'b111);
    in1 = 5'h00; in2 = 5'h1F; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    head("mixed0", 1'b1, 3'b111, 10'h3E0);
    check("mixed0.out", 32'(out), 32'd0);
    check("mixed0.mt1", 32'(mon_temp1), 32'd0);
    step();
    head("mixed.retired", 1'b0, 3'b000, 10'h000);

    // Staggered consumers: primary, lane0, lane2, idle, lane1
    set_ready(1'b0, 3'b000);
    in1 = 5'h1F; in2 = 5'h15; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    head("stag.c1", 1'b1, 3'b111, 10'h2BF);
    set_ready(1'b1, 3'b000);
    step();
    head("stag.c2", 1'b0, 3'b111, 10'h2BF);
    set_ready(1'b0, 3'b001);
    step();
    head("stag.c3", 1'b0, 3'b110, 10'h2BF);
    set_ready(1'b0, 3'b100);
    step();
    head("stag.c4", 1'b0, 3'b010, 10'h2BF);
    set_ready(1'b0, 3'b000);
    step();
    head("stag.c5", 1'b0, 3'b010, 10'h2BF);
    check("stag.out", 32'(out), 32'd1);
    set_ready(1'b0, 3'b010);
    step();
    head("stag.retired", 1'b0, 3'b000, 10'h000);

    // Back-pressure: lane1 blocked, three operands offered
    set_ready(1'b1, 3'b101);
    in1 = 5'h01; in2 = 5'h01; in_valid = 1'b1;
    step();
    in1 = 5'h1F; in2 = 5'h02;
    step();
    check("bp.full.in_ready", 32'(in_ready), 32'd0);
    in1 = 5'h03; in2 = 5'h03;
    step();
    check("bp.held.in_ready", 32'(in_ready), 32'd0);
    head("bp.headA", 1'b0, 3'b010, 10'h021);
    set_ready(1'b1, 3'b111);
    step();
    head("bp.headB", 1'b1, 3'b111, 10'h05F);
    check("bp.B.in_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    head("bp.headC", 1'b1, 3'b111, 10'h063);
    step();
    head("bp.empty", 1'b0, 3'b000, 10'h000);
    check("bp.empty.in_ready", 32'(in_ready), 32'd1);

    // Streaming with pointer wrap, one operand per cycle
    set_ready(1'b1, 3'b111);
    for (int i = 0; i < 8; i++) begin
      s_in1 = 5'(i * 7 + 3);
      s_in2 = 5'(i * 3 + 1);
      in1 = s_in1; in2 = s_in2; in_valid = 1'b1;
      step();
      head($sformatf("stream%0d", i), 1'b1, 3'b111, {s_in2, s_in1});
      check($sformatf("stream%0d.out", i), 32'(out), 32'(s_in1 == 5'h1F));
      check($sformatf("stream%0d.in_ready", i), 32'(in_ready), 32'd1);
    end
    in_valid = 1'b0;
    step();
    head("stream.empty", 1'b0, 3'b000, 10'h000);

    // Reset in the middle of a cycle with two entries queued
    set_ready(1'b0, 3'b000);
    in1 = 5'h07; in2 = 5'h01; in_valid = 1'b1;
    step();
    in1 = 5'h09; in2 = 5'h02;
    step();
    in_valid = 1'b0;
    head("pre.rst", 1'b1, 3'b111, 10'h027);
    #2;
    ASYNCRESET = 1'b1;
    #1;
    head("mid.rst", 1'b0, 3'b000, 10'h000);
    check("mid.rst.in_ready", 32'(in_ready), 32'd0);
    step();
    ASYNCRESET = 1'b0;
    #1;
    check("post.rst.in_ready", 32'(in_ready), 32'd1);
    step();
    head("post.rst.empty", 1'b0, 3'b000, 10'h000);
    in1 = 5'h11; in2 = 5'h0C; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    head("post.rst.first", 1'b1, 3'b111, 10'h191);
    set_ready(1'b1, 3'b111);
    step();
    head("post.rst.retired", 1'b0, 3'b000, 10'h000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Overall time bound so the bench always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1, "timeout");
  end

endmodule
